// File: rtl/msp430_bb_ext_responder.sv
// Blackbone external-port responder: a private scratch RAM per tile port plus a
// shared mailbox fabric with one receive FIFO per node and lowest-index push arbitration.
module msp430_bb_ext_responder #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int NODES      = 16,
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NODES-1:0][AW-1:0]   bb_ext_addr_i,
    input  logic [NODES-1:0][DW-1:0]   bb_ext_din_i,
    input  logic [NODES-1:0]           bb_ext_en_i,
    input  logic [NODES-1:0]           bb_ext_we_i,
    output logic [NODES-1:0][DW-1:0]   bb_ext_dout_o
);

    localparam int NW = $clog2(NODES);
    localparam int RW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

    logic [NODES-1:0]          w_req, w_mb, w_cand, w_pop, w_full, w_empty;
    logic [NODES-1:0]          w_acc, w_push, w_sel_v;
    logic [NODES-1:0][1:0]     w_reg;
    logic [NODES-1:0][NW-1:0]  w_txdest, w_sel;
    logic [NODES-1:0][DW-1:0]  w_push_data;

    // Per destination FIFO: the lowest-index candidate wins; a pop this cycle frees a full slot.
    always_comb begin
        w_sel_v     = '0;
        w_sel       = '0;
        w_push      = '0;
        w_push_data = '0;
        w_acc       = '0;
        for (int d = 0; d < NODES; d++) begin
            for (int n = NODES - 1; n >= 0; n--) begin
                if (w_cand[n] && (w_txdest[n] == NW'(d))) begin
                    w_sel_v[d] = 1'b1;
                    w_sel[d]   = NW'(n);
                end
            end
        end
        for (int d = 0; d < NODES; d++) begin
            w_push[d]      = w_sel_v[d] && (!w_full[d] || w_pop[d]);
            w_push_data[d] = bb_ext_din_i[w_sel[d]];
            if (w_push[d]) begin
                w_acc[w_sel[d]] = 1'b1;
            end
        end
    end

    for (genvar n = 0; n < NODES; n++) begin : g_port
        logic [DW-1:0] r_ram  [RAM_WORDS];
        logic [DW-1:0] r_fifo [FIFO_DEPTH];
        logic [DW-1:0] r_dout_p1;
        logic [NW-1:0] r_txdest;
        logic          r_drop;
        logic [PW-1:0] r_wp, r_rp;
        logic [PW:0]   r_cnt;
        logic [RW-1:0] w_idx;
        logic          w_rd;
        logic [DW-1:0] w_rdata, w_status;
        logic          w_unused_addr;

        assign w_req[n]    = bb_ext_en_i[n] && !rst;
        assign w_mb[n]     = bb_ext_addr_i[n][AW-1];
        assign w_reg[n]    = bb_ext_addr_i[n][3:2];
        assign w_idx       = bb_ext_addr_i[n][2 +: RW];
        assign w_rd        = w_req[n] && !bb_ext_we_i[n];
        assign w_cand[n]   = w_req[n] && bb_ext_we_i[n] && w_mb[n] && (w_reg[n] == 2'd0);
        assign w_pop[n]    = w_rd && w_mb[n] && (w_reg[n] == 2'd2) && !w_empty[n];
        assign w_empty[n]  = (r_cnt == '0);
        assign w_full[n]   = (r_cnt == FULL_CNT);
        assign w_txdest[n] = r_txdest;
        assign bb_ext_dout_o[n] = r_dout_p1;
        assign w_unused_addr = ^{bb_ext_addr_i[n][1:0], bb_ext_addr_i[n][AW-2:RW+2]};

        always_comb begin
            w_status         = '0;
            w_status[7:0]    = 8'(r_cnt);
            w_status[8]      = w_empty[n];
            w_status[9]      = w_full[r_txdest];
            w_status[DW-1]   = r_drop;
            w_rdata          = '0;
            if (!w_mb[n]) begin
                w_rdata = r_ram[w_idx];
            end else begin
                case (w_reg[n])
                    2'd1:    w_rdata = DW'(r_txdest);
                    2'd2:    if (!w_empty[n]) w_rdata = r_fifo[r_rp];
                    2'd3:    w_rdata = w_status;
                    default: w_rdata = '0;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_req[n] && bb_ext_we_i[n] && !w_mb[n]) begin
                r_ram[w_idx] <= bb_ext_din_i[n];
            end
        end

        always_ff @(posedge clk) begin
            if (w_push[n]) begin
                r_fifo[r_wp] <= w_push_data[n];
            end
        end

        // Stage p1: registered read data and mailbox control state.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_dout_p1 <= '0;
                r_txdest  <= '0;
                r_drop    <= 1'b0;
                r_wp      <= '0;
                r_rp      <= '0;
                r_cnt     <= '0;
            end else begin
                if (w_rd) begin
                    r_dout_p1 <= w_rdata;
                end
                if (w_req[n] && bb_ext_we_i[n] && w_mb[n] && (w_reg[n] == 2'd1)) begin
                    r_txdest <= bb_ext_din_i[n][NW-1:0];
                end
                if (w_cand[n] && !w_acc[n]) begin
                    r_drop <= 1'b1;
                end else if (w_rd && w_mb[n] && (w_reg[n] == 2'd3)) begin
                    r_drop <= 1'b0;
                end
                if (w_push[n]) begin
                    r_wp <= r_wp + PW'(1);
                end
                if (w_pop[n]) begin
                    r_rp <= r_rp + PW'(1);
                end
                if (w_push[n] && !w_pop[n]) begin
                    r_cnt <= r_cnt + (PW+1)'(1);
                end else if (!w_push[n] && w_pop[n]) begin
                    r_cnt <= r_cnt - (PW+1)'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_msp430_bb_ext_responder.sv
// Scoreboard bench for msp430_bb_ext_responder: each read pushes its expected data,
// which a monitor compares one cycle later; tasks add inline checks of their own.
module tb_msp430_bb_ext_responder;

    localparam logic [31:0] TXD = 32'h8000_0000;
    localparam logic [31:0] DST = 32'h8000_0004;
    localparam logic [31:0] RXD = 32'h8000_0008;
    localparam logic [31:0] STS = 32'h8000_000C;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0][31:0] addr, din, dout;
    logic [15:0]       en, we;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        string       name;
    } exp_t;
    exp_t q[$];

    msp430_bb_ext_responder dut (
        .clk           (clk),
        .rst           (rst),
        .bb_ext_addr_i (addr),
        .bb_ext_din_i  (din),
        .bb_ext_en_i   (en),
        .bb_ext_we_i   (we),
        .bb_ext_dout_o (dout)
    );

    always #5 clk = ~clk;

    // Read results land on the edge after the request; compare just after that edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        while (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (dout[e.port] !== e.data) begin
                failures++;
                $display("FAIL %s port=%0d got=%h expected=%h", e.name, e.port, dout[e.port], e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic drv(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
        en[p] = 1'b1; we[p] = w; addr[p] = a; din[p] = d;
    endtask

    task automatic rd(input int p, input logic [31:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        drv(p, a, 1'b0, 32'h0);
        x.port = p; x.data = e; x.name = nm;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        en = '0; we = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '0; we = '0; addr = '0; din = '0;
        step(); step();
        rst = 1'b0;
        checks++;
        if (dout !== '0) begin
            failures++;
            $display("FAIL reset_dout got=%h expected=0", dout);
        end
        rd(0, STS, 32'h100, "reset_status");
        rd(1, DST, 32'h0, "reset_txdest");
        rd(2, TXD, 32'h0, "txdata_reads_0");
        step();
    endtask

    task automatic test_ram();
        drv(3, 32'h10, 1'b1, 32'hDEADBEEF);
        drv(4, 32'h10, 1'b1, 32'h12345678);
        step();
        rd(3, 32'h10, 32'hDEADBEEF, "ram_rd_p3");
        rd(4, 32'h10, 32'h12345678, "ram_private_p4");
        step();
        drv(3, 32'h14, 1'b1, 32'h0BADF00D);
        step();
        checks++;
        if (dout[3] !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL write_holds_dout got=%h expected=%h", dout[3], 32'hDEADBEEF);
        end
        rd(3, 32'h410, 32'hDEADBEEF, "alias_rd");
        drv(4, 32'h410, 1'b1, 32'hCAFE0001);
        step();
        rd(4, 32'h10, 32'hCAFE0001, "alias_wr");
        rd(3, 32'h14, 32'h0BADF00D, "ram_rd_14");
        step();
    endtask

    task automatic test_mailbox();
        drv(0, DST, 1'b1, 32'hFFFF_FFF5);
        step();
        drv(0, TXD, 1'b1, 32'h11); step();
        drv(0, TXD, 1'b1, 32'h22); step();
        rd(0, DST, 32'h5, "txdest_rb");
        rd(5, STS, 32'h002, "mb_status_cnt2");
        step();
        rd(5, RXD, 32'h11, "mb_pop1"); step();
        rd(5, RXD, 32'h22, "mb_pop2"); step();
        rd(5, STS, 32'h100, "mb_status_empty"); step();
        rd(5, RXD, 32'h0, "mb_pop_empty"); step();
        rd(5, STS, 32'h100, "mb_cnt_stays0"); step();
        drv(0, TXD, 1'b1, 32'h33);
        rd(5, RXD, 32'h0, "push_not_same_cycle");
        step();
        rd(5, RXD, 32'h33, "push_next_cycle"); step();
        drv(5, DST, 1'b1, 32'h5); step();
        drv(5, TXD, 1'b1, 32'h55); step();
        rd(5, RXD, 32'h55, "self_push"); step();
    endtask

    task automatic test_full_drop();
        drv(1, DST, 1'b1, 32'h2); step();
        for (int i = 0; i < 5; i++) begin
            drv(1, TXD, 1'b1, 32'h101 + 32'(i));
            step();
        end
        rd(1, STS, 32'h8000_0300, "drop_and_full");
        rd(2, STS, 32'h004, "full_count4");
        step();
        rd(1, STS, 32'h0000_0300, "drop_cleared"); step();
        for (int i = 0; i < 4; i++) begin
            rd(2, RXD, 32'h101 + 32'(i), "full_pop_order");
            step();
        end
        rd(2, STS, 32'h100, "full_drained"); step();
    endtask

    task automatic test_collision();
        drv(6, DST, 1'b1, 32'h0);
        drv(9, DST, 1'b1, 32'h0);
        step();
        drv(6, TXD, 1'b1, 32'hA);
        drv(9, TXD, 1'b1, 32'hB);
        step();
        rd(0, STS, 32'h001, "coll_count1");
        rd(6, STS, 32'h100, "coll_winner_nodrop");
        rd(9, STS, 32'h8000_0100, "coll_loser_drop");
        step();
        rd(0, RXD, 32'hA, "coll_data"); step();
        rd(0, RXD, 32'h0, "coll_only_one"); step();
    endtask

    task automatic test_push_pop_full();
        drv(7, DST, 1'b1, 32'h2); step();
        for (int i = 0; i < 4; i++) begin
            drv(7, TXD, 1'b1, 32'h71 + 32'(i));
            step();
        end
        rd(2, STS, 32'h004, "pp_full"); step();
        rd(2, RXD, 32'h71, "pp_old_head");
        drv(7, TXD, 1'b1, 32'h77);
        step();
        rd(7, STS, 32'h300, "pp_no_drop");
        rd(2, STS, 32'h004, "pp_count_kept");
        step();
        rd(2, RXD, 32'h72, "pp_pop2"); step();
        rd(2, RXD, 32'h73, "pp_pop3"); step();
        rd(2, RXD, 32'h74, "pp_pop4"); step();
        rd(2, RXD, 32'h77, "pp_last"); step();
        rd(2, STS, 32'h100, "pp_drained"); step();
    endtask

    task automatic test_reset_mid();
        drv(0, DST, 1'b1, 32'h3); step();
        drv(0, TXD, 1'b1, 32'h31); step();
        drv(0, TXD, 1'b1, 32'h32); step();
        rd(3, STS, 32'h002, "rm_count2"); step();
        rd(3, 32'h10, 32'hDEADBEEF, "rm_ram_before"); step();
        rst = 1'b1;
        drv(3, RXD, 1'b0, 32'h0);
        step();
        rst = 1'b0;
        checks++;
        if (dout !== '0) begin
            failures++;
            $display("FAIL rm_dout_zero got=%h expected=0", dout);
        end
        rd(3, STS, 32'h100, "rm_status_empty");
        rd(0, DST, 32'h0, "rm_txdest_zero");
        step();
        rd(3, 32'h10, 32'hDEADBEEF, "rm_ram_kept"); step();
        rd(3, RXD, 32'h0, "rm_fifo_flushed"); step();
    endtask

    initial begin
        test_reset();
        test_ram();
        test_mailbox();
        test_full_drop();
        test_collision();
        test_push_pop_full();
        test_reset_mid();
        step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
